sha2_core_param: RTL

- Next-generation iterative SHA-2 compression core: SHA-256 and SHA-224 modes, R rounds per clock (R = 1, 2 or 4), internal multi-block chaining, and valid/ready handshakes on both sides.
- Sits between the message padder/block buffer and the digest consumer.
- One 512-bit pre-padded block is accepted per transaction; the digest is presented after the block flagged last.

---
 rtl/sha2_core_param.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/sha2_core_param.sv
// Iterative SHA-256/SHA-224 compression core: ROUNDS_PER_CYCLE chained rounds per
// clock over a 16-word circular schedule buffer, with multi-block chaining.
module sha2_core_param #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int PIPE_OUT         = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_in,
    input  logic         first,
    input  logic         last,
    input  logic         mode_224,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest,
    output logic         busy
);
    // Both sides: a transfer happens on a rising edge with valid and ready high;
    // out_valid, once raised, holds digest stable until that transfer.
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rounds
        $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, COMP, FINAL, OUT} state_t;

    localparam logic [5:0] T_LAST = 6'(64 - ROUNDS_PER_CYCLE);
    localparam logic [5:0] T_STEP = 6'(ROUNDS_PER_CYCLE);

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction
    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction
    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    state_t       state;
    state_t       state_next;
    logic [5:0]   t_cnt;
    logic         mode_q;
    logic         last_q;
    logic         pipe_valid;
    logic [255:0] digest_q;
    logic [31:0]  h_reg [8];
    logic [31:0]  wv    [8];
    logic [31:0]  w     [16];
    logic [31:0]  w_n   [16];
    logic [31:0]  wv_n  [8];
    logic [31:0]  h_sum [8];
    logic [255:0] final_digest;
    logic [255:0] held_digest;

    // Schedule words for t >= 16 overwrite slot t mod 16, so later rounds of the
    // same cycle already see them.
    always_comb begin : rounds
        logic [5:0]  idx;
        logic [31:0] wt;
        logic [31:0] t1;
        logic [31:0] t2;
        w_n  = w;
        wv_n = wv;
        idx  = '0;
        wt   = '0;
        t1   = '0;
        t2   = '0;
        for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            idx = t_cnt + 6'(k);
            if (idx >= 6'd16)
                wt = ssig1(w_n[idx[3:0] - 4'd2]) + w_n[idx[3:0] - 4'd7]
                   + ssig0(w_n[idx[3:0] + 4'd1]) + w_n[idx[3:0]];
            else
                wt = w_n[idx[3:0]];
            w_n[idx[3:0]] = wt;
            t1 = wv_n[7] + bsig1(wv_n[4]) + ch(wv_n[4], wv_n[5], wv_n[6]) + K[idx] + wt;
            t2 = bsig0(wv_n[0]) + maj(wv_n[0], wv_n[1], wv_n[2]);
            wv_n[7] = wv_n[6];
            wv_n[6] = wv_n[5];
            wv_n[5] = wv_n[4];
            wv_n[4] = wv_n[3] + t1;
            wv_n[3] = wv_n[2];
            wv_n[2] = wv_n[1];
            wv_n[1] = wv_n[0];
            wv_n[0] = t1 + t2;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) h_sum[i] = h_reg[i] + wv[i];
        final_digest = {h_sum[0], h_sum[1], h_sum[2], h_sum[3], h_sum[4], h_sum[5], h_sum[6],
                        mode_q ? 32'h0 : h_sum[7]};
        held_digest  = {h_reg[0], h_reg[1], h_reg[2], h_reg[3], h_reg[4], h_reg[5], h_reg[6],
                        mode_q ? 32'h0 : h_reg[7]};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = COMP;
            COMP:    if (t_cnt == T_LAST) state_next = FINAL;
            FINAL:   state_next = last_q ? OUT : IDLE;
            OUT:     if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT) && ((PIPE_OUT == 0) || pipe_valid);
    assign digest    = digest_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            t_cnt      <= '0;
            mode_q     <= 1'b0;
            last_q     <= 1'b0;
            pipe_valid <= 1'b0;
            digest_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= IV256[i];
                wv[i]    <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (in_valid) begin
                    last_q <= last;
                    t_cnt  <= '0;
                    if (first) begin
                        mode_q <= mode_224;
                        for (int i = 0; i < 8; i++) begin
                            h_reg[i] <= mode_224 ? IV224[i] : IV256[i];
                            wv[i]    <= mode_224 ? IV224[i] : IV256[i];
                        end
                    end else begin
                        for (int i = 0; i < 8; i++) wv[i] <= h_reg[i];
                    end
                end
                COMP: begin
                    for (int i = 0; i < 8; i++) wv[i] <= wv_n[i];
                    t_cnt <= t_cnt + T_STEP;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) h_reg[i] <= h_sum[i];
                    if (PIPE_OUT == 0 && last_q) digest_q <= final_digest;
                end
                OUT: if (PIPE_OUT != 0) begin
                    // Extra output stage: capture the chained H, then raise out_valid.
                    if (!pipe_valid) begin
                        pipe_valid <= 1'b1;
                        digest_q   <= held_digest;
                    end else if (out_ready) begin
                        pipe_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            for (int i = 0; i < 16; i++) w[i] <= block_in[511 - 32*i -: 32];
        end else if (state == COMP) begin
            for (int i = 0; i < 16; i++) w[i] <= w_n[i];
        end
    end
endmodule
